// File: rtl/irq_priority_ctrl_if.sv
// Bus between the interrupt controller and its CPU/control-logic side:
// request pins, register writes, the INTA handshake and status readback.
interface irq_priority_ctrl_if #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
);
  logic [NUM_IRQ-1:0] irs;
  logic               imr_we;
  logic [NUM_IRQ-1:0] imr_data;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [7:0]         cfg_data;
  logic               inta;
  logic               int_out;
  logic [VEC_W-1:0]   vec_out;
  logic               vec_valid;
  logic [NUM_IRQ-1:0] irr_o;
  logic [NUM_IRQ-1:0] isr_o;
  logic [NUM_IRQ-1:0] imr_o;

  modport master (
    output irs, imr_we, imr_data, cfg_we, cfg_sel, cfg_data, inta,
    input  int_out, vec_out, vec_valid, irr_o, isr_o, imr_o
  );

  modport slave (
    input  irs, imr_we, imr_data, cfg_we, cfg_sel, cfg_data, inta,
    output int_out, vec_out, vec_valid, irr_o, isr_o, imr_o
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Parametrised priority interrupt controller: latches and masks requests,
// resolves nested/rotating priority and runs the two-pulse INTA handshake.
module irq_priority_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input logic                clk,
  input logic                rst_n,
  irq_priority_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_IRQ);

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_IRQ-1:0] irq_vec_t;
  typedef enum logic { IDLE, ACK1 } state_t;

  typedef enum logic [2:0] {
    OCW_ROT_CLR    = 3'b000,
    OCW_NS_EOI     = 3'b001,
    OCW_NOP        = 3'b010,
    OCW_SP_EOI     = 3'b011,
    OCW_ROT_SET    = 3'b100,
    OCW_NS_EOI_ROT = 3'b101,
    OCW_SET_PRI    = 3'b110,
    OCW_SP_EOI_ROT = 3'b111
  } ocw2_cmd_t;

  localparam logic [1:0] SEL_ICW  = 2'b00;
  localparam logic [1:0] SEL_OCW2 = 2'b01;
  localparam logic [1:0] SEL_BASE = 2'b10;

  irq_vec_t         irr, isr, imr, prev_irs;
  logic             aeoi, level_mode, rot_aeoi;
  idx_t             lowest_ptr;
  logic [VEC_W-1:0] base;
  state_t           state;
  idx_t             cur;
  logic             spur;
  logic             int_q, vec_valid_q;
  logic [VEC_W-1:0] vec_q;

  // Priority scan results
  irq_vec_t pending;
  idx_t     scan_idx;
  logic     cand_valid, top_valid;
  idx_t     cand_idx, top_idx;

  // Next-state values for the shared status registers
  irq_vec_t  irr_next, isr_next, irr_clr, isr_set, isr_clr;
  idx_t      ptr_next, ocw_level;
  logic      rot_next;
  logic      icw_we, ocw2_we, base_we;
  logic      ack_take, ack_done;
  ocw2_cmd_t ocw_cmd;

  assign pending   = irr & ~imr;
  assign icw_we    = bus.cfg_we && (bus.cfg_sel == SEL_ICW);
  assign ocw2_we   = bus.cfg_we && (bus.cfg_sel == SEL_OCW2);
  assign base_we   = bus.cfg_we && (bus.cfg_sel == SEL_BASE);
  assign ocw_cmd   = ocw2_cmd_t'(bus.cfg_data[7:5]);
  assign ocw_level = idx_t'(bus.cfg_data[IDX_W-1:0]);
  assign ack_take  = (state == IDLE) && bus.inta && cand_valid;
  assign ack_done  = (state == ACK1) && bus.inta;

  // Walk levels from highest to lowest priority. The first in-service level
  // met both names the non-specific EOI target and blocks everything below.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    top_valid  = 1'b0;
    top_idx    = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      scan_idx = lowest_ptr + idx_t'(k + 1);
      if (!cand_valid && !top_valid && !isr[scan_idx] && pending[scan_idx]) begin
        cand_valid = 1'b1;
        cand_idx   = scan_idx;
      end
      if (!top_valid && isr[scan_idx]) begin
        top_valid = 1'b1;
        top_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    irr_clr  = '0;
    isr_set  = '0;
    isr_clr  = '0;
    ptr_next = lowest_ptr;
    rot_next = rot_aeoi;

    if (ocw2_we) begin
      unique case (ocw_cmd)
        OCW_NS_EOI: if (top_valid) isr_clr[top_idx] = 1'b1;
        OCW_SP_EOI: if (|isr) isr_clr[ocw_level] = 1'b1;
        OCW_NS_EOI_ROT: if (top_valid) begin
          isr_clr[top_idx] = 1'b1;
          ptr_next         = top_idx;
        end
        OCW_SP_EOI_ROT: if (|isr) begin
          isr_clr[ocw_level] = 1'b1;
          ptr_next           = ocw_level;
        end
        OCW_ROT_SET: rot_next = 1'b1;
        OCW_ROT_CLR: rot_next = 1'b0;
        OCW_SET_PRI: ptr_next = ocw_level;
        OCW_NOP:     ;
      endcase
    end

    if (ack_take) begin
      isr_set[cand_idx] = 1'b1;
      irr_clr[cand_idx] = 1'b1;
    end

    if (ack_done && aeoi && !spur) begin
      isr_clr[cur] = 1'b1;
      if (rot_aeoi) ptr_next = cur;
    end

    // A set in the same cycle as an EOI on the same level wins.
    isr_next = (isr & ~isr_clr) | isr_set;
    // An edge arriving with the acknowledge clear re-latches the request.
    irr_next = level_mode ? (bus.irs & ~irr_clr)
                          : ((irr & ~irr_clr) | (bus.irs & ~prev_irs));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr         <= '0;
      isr         <= '0;
      imr         <= '0;
      prev_irs    <= '0;
      aeoi        <= 1'b0;
      level_mode  <= 1'b0;
      rot_aeoi    <= 1'b0;
      lowest_ptr  <= idx_t'(NUM_IRQ - 1);
      base        <= '0;
      state       <= IDLE;
      cur         <= '0;
      spur        <= 1'b0;
      int_q       <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      irr        <= irr_next;
      isr        <= isr_next;
      lowest_ptr <= ptr_next;
      rot_aeoi   <= rot_next;
      prev_irs   <= bus.irs;
      if (bus.imr_we) imr <= bus.imr_data;
      if (icw_we) begin
        aeoi       <= bus.cfg_data[0];
        level_mode <= bus.cfg_data[1];
      end
      if (base_we) base <= VEC_W'(bus.cfg_data);

      int_q       <= (state == IDLE) && cand_valid;
      vec_valid_q <= 1'b0;

      unique case (state)
        IDLE: if (bus.inta) begin
          state <= ACK1;
          cur   <= cand_valid ? cand_idx : idx_t'(NUM_IRQ - 1);
          spur  <= !cand_valid;
        end
        ACK1: if (bus.inta) begin
          state       <= IDLE;
          vec_q       <= {base[VEC_W-1:IDX_W], cur};
          vec_valid_q <= 1'b1;
        end
      endcase
    end
  end

  // Low base bits are replaced by the level number and never read.
  logic unused_base_lo;
  assign unused_base_lo = ^base[IDX_W-1:0];

  assign bus.int_out   = int_q;
  assign bus.vec_out   = vec_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.irr_o     = irr;
  assign bus.isr_o     = isr;
  assign bus.imr_o     = imr;
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: 8-line instance for the main scenarios
// and a 16-line instance for the wider index/vector case.
module tb_irq_priority_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_priority_ctrl_if #(.NUM_IRQ(8),  .VEC_W(8)) bus ();
  irq_priority_ctrl_if #(.NUM_IRQ(16), .VEC_W(8)) bus16 ();

  irq_priority_ctrl #(.NUM_IRQ(8),  .VEC_W(8)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  irq_priority_ctrl #(.NUM_IRQ(16), .VEC_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.irs = '0;   bus.imr_we = 1'b0;   bus.imr_data = '0;
    bus.cfg_we = 1'b0;   bus.cfg_sel = '0;   bus.cfg_data = '0;   bus.inta = 1'b0;
    bus16.irs = '0; bus16.imr_we = 1'b0; bus16.imr_data = '0;
    bus16.cfg_we = 1'b0; bus16.cfg_sel = '0; bus16.cfg_data = '0; bus16.inta = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_data = data;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic imr_write(input logic [7:0] data);
    bus.imr_we = 1'b1; bus.imr_data = data;
    step();
    bus.imr_we = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int n = 0;
    while (bus.int_out !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, bus.int_out, 1'b1);
  endtask

  task automatic acknowledge(input string tag, input logic [7:0] exp_vec);
    bus.inta = 1'b1; step(); bus.inta = 1'b0; step();
    bus.inta = 1'b1; step(); bus.inta = 1'b0;
    check({tag, "_valid"}, bus.vec_valid, 1'b1);
    check({tag, "_vec"}, bus.vec_out, exp_vec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_valid;
    idle_inputs();

    // Basic edge, fully nested
    do_reset();
    check("rst_int", bus.int_out, 1'b0);
    check("rst_vec", bus.vec_out, 8'h00);
    check("rst_valid", bus.vec_valid, 1'b0);
    check("rst_irr", bus.irr_o, 8'h00);
    check("rst_isr", bus.isr_o, 8'h00);
    check("rst_imr", bus.imr_o, 8'h00);
    bus.irs = 8'h28;
    step();
    check("basic_irr", bus.irr_o, 8'h28);
    check("basic_int_t1", bus.int_out, 1'b0);
    step();
    check("basic_int_t2", bus.int_out, 1'b1);
    bus.inta = 1'b1; step(); bus.inta = 1'b0;
    check("basic_int_hold", bus.int_out, 1'b1);
    check("basic_isr", bus.isr_o, 8'h08);
    check("basic_irr_clr", bus.irr_o, 8'h20);
    step();
    check("basic_int_drop", bus.int_out, 1'b0);
    bus.inta = 1'b1; step(); bus.inta = 1'b0;
    check("basic_valid", bus.vec_valid, 1'b1);
    check("basic_vec", bus.vec_out, 8'h03);
    step();
    check("basic_valid_1cyc", bus.vec_valid, 1'b0);
    step(3);
    check("basic_nested_block", bus.int_out, 1'b0);
    cfg_write(2'b01, 8'h20);
    check("basic_eoi_isr", bus.isr_o, 8'h00);
    step();
    check("basic_reassert", bus.int_out, 1'b1);
    acknowledge("basic_l5", 8'h05);
    bus.irs = '0;

    // Masking
    do_reset();
    imr_write(8'h01);
    bus.irs = 8'h01;
    step();
    bus.irs = '0;
    check("mask_irr", bus.irr_o, 8'h01);
    step(2);
    check("mask_int_low", bus.int_out, 1'b0);
    imr_write(8'h00);
    check("mask_int_same", bus.int_out, 1'b0);
    step();
    check("mask_int_high", bus.int_out, 1'b1);
    acknowledge("mask_l0", 8'h00);

    // Spurious (level mode) then specific EOI
    do_reset();
    cfg_write(2'b00, 8'h02);
    bus.irs = 8'h04;
    wait_int("spur_int");
    bus.irs = '0;
    step();
    check("spur_irr", bus.irr_o, 8'h00);
    acknowledge("spur", 8'h07);
    check("spur_isr", bus.isr_o, 8'h00);
    bus.irs = 8'h10;
    wait_int("lvl4_int");
    acknowledge("lvl4", 8'h04);
    check("lvl4_isr", bus.isr_o, 8'h10);
    bus.irs = 8'h12;
    wait_int("lvl1_int");
    acknowledge("lvl1", 8'h01);
    check("lvl1_isr", bus.isr_o, 8'h12);
    bus.irs = '0;
    cfg_write(2'b01, 8'h64);
    check("sp_eoi_isr", bus.isr_o, 8'h02);

    // Rotate on AEOI
    do_reset();
    cfg_write(2'b10, 8'h40);
    cfg_write(2'b00, 8'h01);
    cfg_write(2'b01, 8'h80);
    bus.irs = 8'h81;
    step();
    bus.irs = '0;
    wait_int("rot_int1");
    acknowledge("rot_l0", 8'h40);
    check("rot_aeoi_isr", bus.isr_o, 8'h00);
    bus.irs = 8'h01;
    step();
    bus.irs = '0;
    wait_int("rot_int2");
    acknowledge("rot_l7", 8'h47);
    wait_int("rot_int3");
    acknowledge("rot_l0b", 8'h40);
    check("rot_irr_empty", bus.irr_o, 8'h00);

    // Reset mid-handshake (priority pointer left rotated to 0 above)
    bus.irs = 8'h08;
    step();
    bus.irs = '0;
    wait_int("rm_int");
    bus.inta = 1'b1; step(); bus.inta = 1'b0;
    check("rm_isr_set", bus.isr_o, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    check("rm_int", bus.int_out, 1'b0);
    check("rm_isr", bus.isr_o, 8'h00);
    check("rm_irr", bus.irr_o, 8'h00);
    check("rm_vec", bus.vec_out, 8'h00);
    check("rm_valid", bus.vec_valid, 1'b0);
    #2 rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.vec_valid === 1'b1) seen_valid = 1'b1;
    end
    check("rm_no_valid", seen_valid, 1'b0);
    bus.irs = 8'h81;
    step();
    bus.irs = '0;
    wait_int("rm_int2");
    acknowledge("rm_nested", 8'h00);
    check("rm_no_aeoi", bus.isr_o, 8'h01);

    // 16-line instance
    do_reset();
    bus16.cfg_we = 1'b1; bus16.cfg_sel = 2'b10; bus16.cfg_data = 8'hA5;
    step();
    bus16.cfg_we = 1'b0;
    bus16.irs = 16'h2000;
    step();
    bus16.irs = '0;
    check("w16_irr", bus16.irr_o, 16'h2000);
    check("w16_int_t1", bus16.int_out, 1'b0);
    step();
    check("w16_int_t2", bus16.int_out, 1'b1);
    bus16.inta = 1'b1; step(); bus16.inta = 1'b0; step();
    bus16.inta = 1'b1; step(); bus16.inta = 1'b0;
    check("w16_valid", bus16.vec_valid, 1'b1);
    check("w16_vec", bus16.vec_out, 8'hAD);
    check("w16_isr", bus16.isr_o, 16'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
